// File: rtl/spi_host_byte_merge.sv
// -----------------------------------------------------------------------------
// spi_host_byte_merge
//
// Receive-side byte packer for the SPI host. Bytes clocked in by the shift
// register are collected into 32-bit words with per-byte lane enables for the
// RX FIFO. A byte flagged as the last of a segment closes a partially filled
// word early; lanes that were never written stay zero with their enable clear.
//
// Parameters
//   ByteOrder     1: first byte of a word lands in [7:0] (little-endian)
//                 0: first byte of a word lands in [31:24] (big-endian)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   byte_i        received byte
//   byte_last_i   byte closes the current segment (qualified by byte_valid_i)
//   byte_valid_i  byte_i / byte_last_i valid
//   byte_ready_o  byte accepted this cycle when byte_valid_i is also high
//   word_o        assembled word, unused lanes zero
//   word_be_o     lane enables, bit k covers word_o[8k+:8]
//   word_valid_o  word_o / word_be_o valid
//   word_ready_i  downstream accepts the word
//   flush_i       synchronous discard of all held data
//   sw_rst_i      synchronous software reset, same effect as flush_i
//   empty_o       no partial word held and no word pending on the output
// -----------------------------------------------------------------------------
module spi_host_byte_merge #(
  parameter bit ByteOrder = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_last_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] word_o,
  output logic [3:0]  word_be_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  input  logic        flush_i,
  input  logic        sw_rst_i,
  output logic        empty_o
);

  logic [31:0] r_acc_data;
  logic [3:0]  r_acc_be;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic [3:0]  r_word_be;
  logic        r_word_valid;

  logic [1:0]  w_lane;
  logic        w_accept;
  logic        w_complete;
  logic        w_handshake;
  logic        w_clear;
  logic [31:0] w_merged_data;
  logic [3:0]  w_merged_be;

  // Byte n of a word goes to lane n (LE) or lane 3-n (BE).
  assign w_lane = ByteOrder ? r_cnt : (2'd3 - r_cnt);

  // The output register is the only buffer, so a byte can only be taken when
  // that register is free or being emptied this cycle.
  assign byte_ready_o = ~r_word_valid | word_ready_i;

  assign w_accept    = byte_valid_i & byte_ready_o;
  assign w_complete  = w_accept & ((r_cnt == 2'd3) | byte_last_i);
  assign w_handshake = r_word_valid & word_ready_i;
  assign w_clear     = flush_i | sw_rst_i;

  // Accumulator plus the incoming byte; lanes never written remain zero.
  assign w_merged_data = r_acc_data | ({24'd0, byte_i} << {w_lane, 3'b000});
  assign w_merged_be   = r_acc_be | (4'b0001 << w_lane);

  // Accumulator: cnt wraps 3 -> 0 only through a completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc_data <= 32'd0;
      r_acc_be   <= 4'd0;
      r_cnt      <= 2'd0;
    end else if (w_clear) begin
      r_acc_data <= 32'd0;
      r_acc_be   <= 4'd0;
      r_cnt      <= 2'd0;
    end else if (w_complete) begin
      r_acc_data <= 32'd0;
      r_acc_be   <= 4'd0;
      r_cnt      <= 2'd0;
    end else if (w_accept) begin
      r_acc_data <= w_merged_data;
      r_acc_be   <= w_merged_be;
      r_cnt      <= r_cnt + 2'd1;
    end
  end

  // Output register. A completion in the same cycle as a handshake replaces
  // the word without dropping valid, giving one word per cycle for 1-byte
  // segments. A flush wins over both; a word handshaken in the flush cycle
  // has already been taken downstream and is simply not re-presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word       <= 32'd0;
      r_word_be    <= 4'd0;
      r_word_valid <= 1'b0;
    end else if (w_clear) begin
      r_word       <= 32'd0;
      r_word_be    <= 4'd0;
      r_word_valid <= 1'b0;
    end else if (w_complete) begin
      r_word       <= w_merged_data;
      r_word_be    <= w_merged_be;
      r_word_valid <= 1'b1;
    end else if (w_handshake) begin
      r_word_valid <= 1'b0;
    end
  end

  assign word_o       = r_word;
  assign word_be_o    = r_word_be;
  assign word_valid_o = r_word_valid;
  assign empty_o      = (r_cnt == 2'd0) & ~r_word_valid;

endmodule

// File: tb/tb_spi_host_byte_merge.sv
// -----------------------------------------------------------------------------
// tb_spi_host_byte_merge
//
// Drives one little-endian and one big-endian instance with the same stimulus
// and compares both against a queue-based model of the byte-to-word packing.
// -----------------------------------------------------------------------------
module tb_spi_host_byte_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_last;
  logic        byte_valid;
  logic        word_ready;
  logic        flush;
  logic        sw_rst;

  logic        rdy_le, valid_le, empty_le;
  logic [31:0] word_le;
  logic [3:0]  be_le;
  logic        rdy_be, valid_be, empty_be;
  logic [31:0] word_be;
  logic [3:0]  be_be;

  always #5 clk = ~clk;

  spi_host_byte_merge #(.ByteOrder(1'b1)) u_le (
    .clk_i(clk), .rst_i(rst), .byte_i(byte_in), .byte_last_i(byte_last),
    .byte_valid_i(byte_valid), .byte_ready_o(rdy_le), .word_o(word_le),
    .word_be_o(be_le), .word_valid_o(valid_le), .word_ready_i(word_ready),
    .flush_i(flush), .sw_rst_i(sw_rst), .empty_o(empty_le)
  );

  spi_host_byte_merge #(.ByteOrder(1'b0)) u_be (
    .clk_i(clk), .rst_i(rst), .byte_i(byte_in), .byte_last_i(byte_last),
    .byte_valid_i(byte_valid), .byte_ready_o(rdy_be), .word_o(word_be),
    .word_be_o(be_be), .word_valid_o(valid_be), .word_ready_i(word_ready),
    .flush_i(flush), .sw_rst_i(sw_rst), .empty_o(empty_be)
  );

  logic [37:0] obs_le, obs_be;
  assign obs_le = {valid_le, empty_le, be_le, word_le};
  assign obs_be = {valid_be, empty_be, be_be, word_be};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes of the open segment, plus the pending output word
  // for each byte order (index 1 = little-endian, 0 = big-endian).
  logic [7:0]  m_seg[$];
  bit          m_valid;
  bit          m_zero;
  logic [31:0] m_word[2];
  logic [3:0]  m_be[2];

  function automatic void model_reset();
    m_seg.delete();
    m_valid = 1'b0;
    m_zero  = 1'b1;
    for (int o = 0; o < 2; o++) begin
      m_word[o] = 32'd0;
      m_be[o]   = 4'd0;
    end
  endfunction

  function automatic bit exp_rdy();
    return !m_valid || word_ready;
  endfunction

  // Evaluated right after a rising edge with the inputs that were sampled.
  function automatic void model_edge();
    bit rdy, acc, done;
    int lane;
    done = 1'b0;
    rdy  = !m_valid || word_ready;
    acc  = byte_valid && rdy;
    if (flush || sw_rst) begin
      model_reset();
      return;
    end
    if (acc) begin
      m_seg.push_back(byte_in);
      if (byte_last || m_seg.size() == 4) begin
        for (int o = 0; o < 2; o++) begin
          m_word[o] = 32'd0;
          m_be[o]   = 4'd0;
          for (int i = 0; i < m_seg.size(); i++) begin
            lane = (o == 1) ? i : 3 - i;
            m_word[o][8*lane +: 8] = m_seg[i];
            m_be[o][lane] = 1'b1;
          end
        end
        m_valid = 1'b1;
        m_zero  = 1'b0;
        m_seg.delete();
        done = 1'b1;
      end
    end
    if (!done && m_valid && word_ready) m_valid = 1'b0;
  endfunction

  function automatic logic [37:0] exp_b(input int o);
    return {m_valid, (m_seg.size() == 0) && !m_valid, m_be[o], m_word[o]};
  endfunction

  // Word/enables are only defined while valid or after a clear.
  function automatic logic [37:0] msk();
    return (m_valid || m_zero) ? {38{1'b1}} : {2'b11, 36'd0};
  endfunction

  task automatic drive(input bit v, input bit l, input logic [7:0] b,
                       input bit wr, input bit fl, input bit sr);
    byte_valid = v;
    byte_last  = l;
    byte_in    = b;
    word_ready = wr;
    flush      = fl;
    sw_rst     = sr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    n_vec++;
    if ({valid_le, valid_be, empty_le, empty_be, rdy_le, rdy_be} !== 6'b001111 ||
        word_le !== 32'd0 || word_be !== 32'd0 || be_le !== 4'd0 || be_be !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state got v=%b%b e=%b%b r=%b%b w=%h/%h be=%h/%h want v=00 e=11 r=11 w=0 be=0",
               valid_le, valid_be, empty_le, empty_be, rdy_le, rdy_be, word_le, word_be, be_le, be_be);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_word();
    logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, bytes[i], 1, 0, 0);
      else       drive(0, 0, 8'h00, 1, 0, 0);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL full_word ready got %b%b want %b", rdy_le, rdy_be, exp_rdy());
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL full_word le got %h want %h", obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL full_word be got %h want %h", obs_be, exp_b(0));
      end
      if (i == 3) begin
        n_vec++;
        if (valid_le !== 1'b1 || word_le !== 32'h44332211 || be_le !== 4'hF) begin
          n_err++; $display("FAIL full_word_const got v=%b w=%h be=%h want v=1 w=44332211 be=f",
                            valid_le, word_le, be_le);
        end
      end
      if (i == 4) begin
        n_vec++;
        if (valid_le !== 1'b0) begin
          n_err++; $display("FAIL full_word_single got valid=%b want 0", valid_le);
        end
      end
    end
  endtask

  task automatic test_partial();
    logic [7:0] bytes[3] = '{8'hAA, 8'hBB, 8'hCC};
    bit         lasts[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, lasts[i], bytes[i], 1, 0, 0);
      else       drive(0, 0, 8'h00, 1, 0, 0);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL partial ready got %b%b want %b", rdy_le, rdy_be, exp_rdy());
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL partial le got %h want %h", obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL partial be got %h want %h", obs_be, exp_b(0));
      end
      if (i == 1) begin
        n_vec++;
        if (valid_be !== 1'b1 || word_be !== 32'hAABB0000 || be_be !== 4'hC) begin
          n_err++; $display("FAIL partial_const got v=%b w=%h be=%h want v=1 w=aabb0000 be=c",
                            valid_be, word_be, be_be);
        end
      end
      if (i == 2) begin
        n_vec++;
        if (valid_be !== 1'b1 || word_be !== 32'hCC000000 || be_be !== 4'h8) begin
          n_err++; $display("FAIL partial_fresh got v=%b w=%h be=%h want v=1 w=cc000000 be=8",
                            valid_be, word_be, be_be);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 11; i++) begin
      if (i < 4)       drive(1, 0, 8'(i + 1), 1, 0, 0);
      else if (i < 9)  drive(1, 0, 8'h05, 0, 0, 0);
      else if (i == 9) drive(1, 0, 8'h05, 1, 0, 0);
      else             drive(0, 0, 8'h00, 1, 0, 0);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL backpressure ready got %b%b want %b", rdy_le, rdy_be, exp_rdy());
      end
      if (i >= 4 && i < 9) begin
        n_vec++;
        if (rdy_le !== 1'b0 || valid_le !== 1'b1 || word_le !== 32'h04030201) begin
          n_err++; $display("FAIL backpressure_hold got r=%b v=%b w=%h want r=0 v=1 w=04030201",
                            rdy_le, valid_le, word_le);
        end
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL backpressure le got %h want %h", obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL backpressure be got %h want %h", obs_be, exp_b(0));
      end
    end
    // Finish off the segment holding 0x05 so the next test starts empty.
    drive(1, 1, 8'h06, 1, 0, 0);
    step();
    drive(0, 0, 8'h00, 1, 0, 0);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1, 1, 8'(i + 1), 1, 0, 0);
      else       drive(0, 0, 8'h00, 1, 0, 0);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL back_to_back ready got %b%b want %b", rdy_le, rdy_be, exp_rdy());
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL back_to_back le got %h want %h", obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL back_to_back be got %h want %h", obs_be, exp_b(0));
      end
      if (i < 6) begin
        n_vec++;
        if (valid_le !== 1'b1 || be_le !== 4'h1 || word_le !== 32'(i + 1)) begin
          n_err++; $display("FAIL back_to_back_const got v=%b be=%h w=%h want v=1 be=1 w=%h",
                            valid_le, be_le, word_le, 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_flush();
    // {flush, sw_rst, valid, last, byte}
    logic [11:0] stim[11] = '{
      {1'b0, 1'b0, 1'b1, 1'b0, 8'h10}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h20},
      {1'b1, 1'b0, 1'b1, 1'b0, 8'h30}, {1'b0, 1'b0, 1'b1, 1'b0, 8'hA1},
      {1'b0, 1'b0, 1'b1, 1'b0, 8'hA2}, {1'b0, 1'b0, 1'b1, 1'b0, 8'hA3},
      {1'b0, 1'b0, 1'b1, 1'b0, 8'hA4}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h77},
      {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}, {1'b0, 1'b0, 1'b1, 1'b1, 8'h88},
      {1'b0, 1'b0, 1'b0, 1'b0, 8'h00}};
    for (int i = 0; i < 11; i++) begin
      drive(stim[i][9], stim[i][8], stim[i][7:0], 1, stim[i][11], stim[i][10]);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL flush ready got %b%b want %b", rdy_le, rdy_be, exp_rdy());
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL flush le got %h want %h", obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL flush be got %h want %h", obs_be, exp_b(0));
      end
      if (i == 2 || i == 8) begin
        n_vec++;
        if (empty_le !== 1'b1 || empty_be !== 1'b1) begin
          n_err++; $display("FAIL flush_empty got %b%b want 11", empty_le, empty_be);
        end
      end
      if (i == 6) begin
        n_vec++;
        if (word_le !== 32'hA4A3A2A1 || be_le !== 4'hF) begin
          n_err++; $display("FAIL flush_word got %h/%h want a4a3a2a1/f", word_le, be_le);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // Reset with a two-byte partial word held.
    drive(1, 0, 8'h10, 1, 0, 0); step();
    drive(1, 0, 8'h20, 1, 0, 0); step();
    drive(0, 0, 8'h00, 1, 0, 0);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (empty_le !== 1'b1 || empty_be !== 1'b1) begin
      n_err++; $display("FAIL async_reset_partial got empty=%b%b want 11", empty_le, empty_be);
    end
    #1 rst = 1'b0;
    model_reset();
    // Reset with a word pending on the output under backpressure.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'hB0 + 8'(i), 0, 0, 0);
      step();
    end
    drive(0, 0, 8'h00, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (valid_le !== 1'b0 || word_le !== 32'd0 || be_le !== 4'd0 || empty_le !== 1'b1 ||
        valid_be !== 1'b0 || word_be !== 32'd0 || empty_be !== 1'b1) begin
      n_err++; $display("FAIL async_reset_word got v=%b%b w=%h/%h e=%b%b want v=00 w=0 e=11",
                        valid_le, valid_be, word_le, word_be, empty_le, empty_be);
    end
    #1 rst = 1'b0;
    model_reset();
    drive(1, 1, 8'h55, 1, 0, 0);
    step();
    n_vec++;
    if (valid_le !== 1'b1 || word_le !== 32'h00000055 || be_le !== 4'h1 ||
        word_be !== 32'h55000000 || be_be !== 4'h8) begin
      n_err++; $display("FAIL async_reset_restart got v=%b w=%h/%h be=%h/%h want v=1 w=00000055/55000000 be=1/8",
                        valid_le, word_le, word_be, be_le, be_be);
    end
    drive(0, 0, 8'h00, 1, 0, 0);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, $urandom % 3 == 0, 8'($urandom), $urandom % 4 != 0,
            $urandom % 40 == 0, $urandom % 50 == 0);
      #1;
      n_vec++;
      if ({rdy_le, rdy_be} !== {2{exp_rdy()}}) begin
        n_err++; $display("FAIL random ready cyc %0d got %b%b want %b", i, rdy_le, rdy_be, exp_rdy());
      end
      step();
      n_vec++;
      if (((obs_le ^ exp_b(1)) & msk()) !== '0) begin
        n_err++; $display("FAIL random le cyc %0d got %h want %h", i, obs_le, exp_b(1));
      end
      n_vec++;
      if (((obs_be ^ exp_b(0)) & msk()) !== '0) begin
        n_err++; $display("FAIL random be cyc %0d got %h want %h", i, obs_be, exp_b(0));
      end
    end
    drive(0, 0, 8'h00, 1, 1, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    model_reset();
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_host_byte_merge.md
# spi_host_byte_merge

Receive-side byte packer for the SPI Host datapath. It accepts bytes from the shift register as the bus clocks them in and assembles them into 32-bit words with per-byte enables for the RX FIFO. It performs the inverse of the TX-side word-to-byte splitting. A segment-end marker closes a partially filled word: unused lanes are zero-padded and their enables are cleared.

## Interface

Parameters:
- ByteOrder, default 1: 1 = little-endian (first byte to bits [7:0]); 0 = big-endian (first byte to bits [31:24]).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- byte_i  input  8  received byte.
- byte_last_i  input  1  byte is the final byte of the current segment; qualified by byte_valid_i.
- byte_valid_i  input  1  byte_i/byte_last_i valid.
- byte_ready_o  output  1  merger accepts the byte this cycle.
- word_o  output  32  assembled word; unused lanes are 0.
- word_be_o  output  4  lane enables; bit k covers word_o[8k+:8].
- word_valid_o  output  1  word_o/word_be_o valid.
- word_ready_i  input  1  downstream accepts the word.
- flush_i  input  1  synchronous discard of all held data.
- sw_rst_i  input  1  synchronous software reset; same effect as flush_i.
- empty_o  output  1  no partial word and no pending output word.

## Operation

- A byte is accepted when byte_valid_i & byte_ready_o.
- byte_ready_o = ~word_valid_o | word_ready_i. This is a combinational path from word_ready_i. There is no dependency on byte_valid_i.
- Accumulator state:
  - acc_data[31:0] and acc_be[3:0].
  - cnt[1:0] counts bytes held in the accumulator (0..3).
  - Lane index for byte n of a word is n when ByteOrder=1, and 3-n when ByteOrder=0.
- Accepted byte with cnt<3 and byte_last_i=0:
  - Write the byte into its lane and set that lane's enable.
  - cnt increments.
  - No output.
- Accepted byte with cnt==3 or byte_last_i=1 (word completion):
  - Merged word (accumulator plus the current byte) loads into the output register. Lanes never written are 0, with enable 0.
  - word_valid_o goes to 1 next cycle.
  - Accumulator clears and cnt returns to 0.
- Output register:
  - Holds word_o/word_be_o stable while word_valid_o & ~word_ready_i.
  - Clears word_valid_o on handshake unless a completion loads a new word in the same cycle. In that case the new word appears with word_valid_o still 1.
- cnt wrap-around: 3 -> 0 only through the completion path. There is no other wrap.
- flush_i | sw_rst_i:
  - Next cycle: cnt=0, acc_data/acc_be=0, word_valid_o=0, word_o=0, word_be_o=0.
  - A byte presented in the same cycle is dropped, although byte_ready_o may read 1.
  - A word handshake in the same cycle is still consumed by the downstream; the merger does not re-present it.
- empty_o = (cnt==0) & ~word_valid_o.

## Timing

- Reset values (asynchronous on rst_i):
  - word_valid_o=0, word_o=0, word_be_o=0.
  - byte_ready_o=1 (combinational result of word_valid_o=0).
  - empty_o=1, cnt=0.
- Latency: the completing byte is accepted in cycle N; word_valid_o=1 in cycle N+1.
- Throughput: one byte per cycle sustained when word_ready_i=1, giving one word every 4 cycles for full words.
- Back-to-back single-byte segments (byte_last_i=1 every byte) with word_ready_i=1: one word per cycle.
- Backpressure:
  - While word_valid_o=1 and word_ready_i=0, byte_ready_o=0 and the accumulator is frozen.
  - word_o/word_be_o must not change until the handshake.
- Reset asserted mid-word: all partial state is lost immediately. The first accepted byte after deassertion is byte 0 of a new word.

## Test plan

- Full word, ByteOrder=1: bytes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready_i=1 -> cycle after 0x44: word_o=0x44332211, word_be_o=0xF, single valid cycle.
- Partial segment, ByteOrder=0: 0xAA, then 0xBB with byte_last_i=1 -> word_o=0xAABB0000, word_be_o=0xC; next byte 0xCC with last starts a fresh word -> word_o=0xCC000000, word_be_o=0x8.
- Backpressure: complete word 0x04030201 with word_ready_i=0 for 5 cycles while byte_valid_i=1 with 0x05 -> byte_ready_o=0 and word_o stable for all 5 cycles; on release, the word is handshaken and 0x05 is accepted in the same cycle.
- Simultaneous handshake and completion: 1-byte segments 0x01..0x06, word_ready_i=1 -> six consecutive valid cycles, word_be_o=0x1 each, no bubbles.
- Flush mid-word: accept 0x10,0x20, then assert flush_i with byte 0x30 valid -> 0x30 dropped, empty_o=1 next cycle; then 0xA1..0xA4 -> word_o=0xA4A3A2A1.
- Async reset mid-operation: assert rst_i between clock edges with cnt=2 and word_valid_o=1 -> word_valid_o=0, word_o=0, empty_o=1 immediately, without waiting for a clock edge.
